// File: rtl/xalu_ctrl.sv
// xalu_ctrl: multi-cycle multiply/divide sequencer owning the HI/LO pair.
// A start pulse in IDLE computes the result into the hi_n/lo_n shadows and
// holds busy for a fixed latency before committing them to HI/LO.
// MTHI/MTLO write HI/LO on the next edge without going busy.
// Optional feature macro: XALU_MADD_EN enables MADD/MADDU (codes 110/111).
// Without it those codes are no-ops and the accumulate adder is not built.
module xalu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  xaluop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef XALU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;
`endif

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] hi_n;
  logic [31:0] lo_n;

  // 64-bit product; unsigned operands are zero-extended so one signed
  // multiplier serves both flavours (result taken mod 2^64).
  function automatic logic [63:0] mul64(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic        sgn);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic signed [63:0] p;
    sx = sgn ? {{32{x[31]}}, x} : {32'b0, x};
    sy = sgn ? {{32{y[31]}}, y} : {32'b0, y};
    p  = sx * sy;
    return p;
  endfunction

  // Divide on magnitudes, then fix signs: quotient truncates toward zero,
  // remainder takes the dividend's sign. A zero divisor keeps HI/LO as-is.
  function automatic logic [63:0] div64(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic        sgn,
                                        input logic [31:0] cur_hi,
                                        input logic [31:0] cur_lo);
    logic        neg_x;
    logic        neg_y;
    logic [31:0] ux;
    logic [31:0] uy;
    logic [31:0] q;
    logic [31:0] r;
    if (y == 32'd0) return {cur_hi, cur_lo};
    neg_x = sgn & x[31];
    neg_y = sgn & y[31];
    ux    = neg_x ? -x : x;
    uy    = neg_y ? -y : y;
    q     = ux / uy;
    r     = ux % uy;
    q     = (neg_x ^ neg_y) ? -q : q;
    r     = neg_x ? -r : r;
    return {r, q};
  endfunction

  // The hazard unit must stall on the request cycle itself, before busy rises.
  assign stall_req = start | busy;

  // Sequencer FSM: issue, count down, commit shadows to HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      hi_n  <= 32'd0;
      lo_n  <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (xaluop)
              OP_MULT, OP_MULTU: begin
                {hi_n, lo_n} <= mul64(a, b, xaluop == OP_MULT);
                cnt          <= MULT_N;
                busy         <= 1'b1;
                state        <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                {hi_n, lo_n} <= div64(a, b, xaluop == OP_DIV, hi, lo);
                cnt          <= DIV_N;
                busy         <= 1'b1;
                state        <= RUN;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
`ifdef XALU_MADD_EN
              OP_MADD, OP_MADDU: begin
                {hi_n, lo_n} <= {hi, lo} + mul64(a, b, xaluop == OP_MADD);
                cnt          <= MULT_N;
                busy         <= 1'b1;
                state        <= RUN;
              end
`endif
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt == 4'd1) begin
            hi    <= hi_n;
            lo    <= lo_n;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= 4'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xalu_ctrl.sv
// tb_xalu_ctrl: directed and randomized checks of the HI/LO sequencer
// against a reference model built from 64-bit integer arithmetic.
module tb_xalu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  xaluop;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_hi;
  logic [31:0] ref_lo;

  xalu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .xaluop(xaluop),
    .a(a), .b(b), .busy(busy), .stall_req(stall_req), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (sampling point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: what HI/LO should become and how long the op keeps busy.
  function automatic void predict(input logic [2:0] op, input logic [31:0] x,
                                  input logic [31:0] y, output int lat,
                                  output logic [31:0] nh, output logic [31:0] nl);
    longint          sx;
    longint          sy;
    longint unsigned ux;
    longint unsigned uy;
    longint          sq;
    longint          sr;
    logic [63:0]     p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    nh = ref_hi;
    nl = ref_lo;
    lat = 0;
    case (op)
      3'd0: begin p = 64'(sx * sy); {nh, nl} = p; lat = MC; end
      3'd1: begin p = 64'(ux * uy); {nh, nl} = p; lat = MC; end
      3'd2: begin
        lat = DC;
        if (y != 0) begin
          sq = sx / sy;
          sr = sx % sy;
          nl = sq[31:0];
          nh = sr[31:0];
        end
      end
      3'd3: begin
        lat = DC;
        if (y != 0) begin
          nl = 32'(ux / uy);
          nh = 32'(ux % uy);
        end
      end
      3'd4: nh = x;
      3'd5: nl = x;
`ifdef XALU_MADD_EN
      3'd6: begin p = {ref_hi, ref_lo} + 64'(sx * sy); {nh, nl} = p; lat = MC; end
      3'd7: begin p = {ref_hi, ref_lo} + 64'(ux * uy); {nh, nl} = p; lat = MC; end
`endif
      default: ;
    endcase
  endfunction

  // Issue one op in the current cycle and follow it to completion,
  // ending in the cycle where a new op may legally be issued.
  task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    int          lat;
    logic [31:0] nh;
    logic [31:0] nl;
    predict(op, x, y, lat, nh, nl);
    check("pre_busy", {63'd0, busy}, 64'd0);
    start  = 1'b1;
    xaluop = op;
    a      = x;
    b      = y;
    #1;
    check("stall_on_start", {63'd0, stall_req}, 64'd1);
    step();
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    if (lat > 0) begin
      for (int k = 1; k <= lat; k++) begin
        check("busy_run", {63'd0, busy}, 64'd1);
        check("stall_run", {63'd0, stall_req}, 64'd1);
        check("done_early", {63'd0, done}, 64'd0);
        check("hilo_hold", {hi, lo}, {ref_hi, ref_lo});
        step();
      end
      ref_hi = nh;
      ref_lo = nl;
      check("busy_end", {63'd0, busy}, 64'd0);
      check("done_pulse", {63'd0, done}, 64'd1);
      check("stall_end", {63'd0, stall_req}, 64'd0);
      check("hilo_commit", {hi, lo}, {ref_hi, ref_lo});
    end else begin
      ref_hi = nh;
      ref_lo = nl;
      check("busy_quick", {63'd0, busy}, 64'd0);
      check("done_quick", {63'd0, done}, 64'd0);
      check("hilo_quick", {hi, lo}, {ref_hi, ref_lo});
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 20));
      1: return $urandom;
      2: case ($urandom_range(0, 3))
           0: return 32'h8000_0000;
           1: return 32'hFFFF_FFFF;
           2: return 32'h0;
           default: return 32'h7FFF_FFFF;
         endcase
      default: return -32'($urandom_range(1, 20));
    endcase
  endfunction

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    xaluop = 3'd0;
    a      = 32'd0;
    b      = 32'd0;
    ref_hi = 32'd0;
    ref_lo = 32'd0;
    step();
    step();
    reset = 1'b0;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_stall", {63'd0, stall_req}, 64'd0);

    // MULT -2 * 3
    do_op(3'd0, 32'hFFFF_FFFE, 32'd3);
    check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    // DIVU 7/2 then DIV -7/2
    do_op(3'd3, 32'd7, 32'd2);
    check("divu_7_2", {hi, lo}, {32'd1, 32'd3});
    do_op(3'd2, -32'd7, 32'd2);
    check("div_m7_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    // MTHI then divide by zero leaves HI/LO unchanged
    do_op(3'd4, 32'h1234, 32'd0);
    check("mthi", {32'd0, hi}, {32'd0, 32'h1234});
    do_op(3'd2, 32'd99, 32'd0);
    check("div_by_zero", {hi, lo}, {32'h1234, 32'hFFFF_FFFD});
    do_op(3'd5, 32'hCAFE, 32'd0);
    check("mtlo", {32'd0, lo}, {32'd0, 32'hCAFE});
    // MULTU max*max then MADDU 1*1
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
    do_op(3'd7, 32'd1, 32'd1);
`ifdef XALU_MADD_EN
    check("maddu", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0002});
`else
    check("maddu_noop", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
`endif
    // DIV followed immediately by MULT in the commit cycle
    do_op(3'd2, 32'd100, 32'd7);
    check("b2b_div", {hi, lo}, {32'd2, 32'd14});
    do_op(3'd0, 32'd3, 32'd4);
    check("b2b_mult", {hi, lo}, {32'd0, 32'd12});

    // Reset in the third busy cycle of a MULT
    start  = 1'b1;
    xaluop = 3'd0;
    a      = 32'd9;
    b      = 32'd9;
    step();
    start = 1'b0;
    step();
    step();
    check("mid_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    step();
    reset  = 1'b0;
    ref_hi = 32'd0;
    ref_lo = 32'd0;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_hilo", {hi, lo}, 64'd0);
    for (int k = 0; k < MC + 3; k++) begin
      check("mid_rst_nodone", {63'd0, done}, 64'd0);
      step();
    end
    check("mid_rst_hilo_after", {hi, lo}, 64'd0);

    // Randomized operations against the reference model
    for (int n = 0; n < 80; n++) begin
      logic [31:0] x;
      logic [31:0] y;
      x = pick_operand();
      y = pick_operand();
      do_op(3'($urandom_range(0, 7)), x, y);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
